// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: shared TAP state encoding, instruction constants and the
// IEEE 1149.1 next-state function used by the oversampled TAP controller.
package jtag_tap_pkg;

   localparam logic [4:0] IR_IDCODE  = 5'h01;
   localparam logic [4:0] IR_BYPASS  = 5'h1F;
   localparam logic [4:0] IR_CAPTURE = 5'b00001;

   typedef enum logic [3:0] {
      TEST_LOGIC_RESET,
      RUN_TEST_IDLE,
      SELECT_DR_SCAN,
      CAPTURE_DR,
      SHIFT_DR,
      EXIT1_DR,
      PAUSE_DR,
      EXIT2_DR,
      UPDATE_DR,
      SELECT_IR_SCAN,
      CAPTURE_IR,
      SHIFT_IR,
      EXIT1_IR,
      PAUSE_IR,
      EXIT2_IR,
      UPDATE_IR
   } tap_state_e;

   typedef enum logic [1:0] {
      DR_SEL_BYPASS,
      DR_SEL_IDCODE,
      DR_SEL_USER
   } dr_sel_e;

   function automatic tap_state_e tap_next_state(input tap_state_e s, input logic tms);
      tap_state_e n;
      n = s;
      case (s)
         TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
         CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         default:          n = TEST_LOGIC_RESET;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/jtag_tap_sync.sv
// jtag_tap_sync: brings the asynchronous JTAG pins into the clk_i domain and
// turns synchronized TCK into registered one-cycle rise/fall strobes.
module jtag_tap_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic tck_i,
   input  logic tms_i,
   input  logic tdi_i,
   input  logic trst_ni,
   output logic tms_o,
   output logic tdi_o,
   output logic trst_no,
   output logic tck_rise_o,
   output logic tck_fall_o
);

   logic [SYNC_STAGES-1:0] tck_q, tms_q, tdi_q, trst_q;
   logic                   tck_prev_q, rise_q, fall_q;

   // Synchronizer chains (trst_n reads as asserted until it has propagated)
   // plus registered edge detection on the synchronized TCK.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         tck_q      <= '0;
         tms_q      <= '0;
         tdi_q      <= '0;
         trst_q     <= '0;
         tck_prev_q <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
      end else begin
         tck_q      <= {tck_q[SYNC_STAGES-2:0], tck_i};
         tms_q      <= {tms_q[SYNC_STAGES-2:0], tms_i};
         tdi_q      <= {tdi_q[SYNC_STAGES-2:0], tdi_i};
         trst_q     <= {trst_q[SYNC_STAGES-2:0], trst_ni};
         tck_prev_q <= tck_q[SYNC_STAGES-1];
         rise_q     <= tck_q[SYNC_STAGES-1] & ~tck_prev_q;
         fall_q     <= ~tck_q[SYNC_STAGES-1] & tck_prev_q;
      end
   end

   assign tms_o      = tms_q[SYNC_STAGES-1];
   assign tdi_o      = tdi_q[SYNC_STAGES-1];
   assign trst_no    = trst_q[SYNC_STAGES-1];
   assign tck_rise_o = rise_q;
   assign tck_fall_o = fall_q;

endmodule

// File: rtl/jtag_tap_oversampled.sv
// jtag_tap_oversampled: device-side IEEE 1149.1 TAP running entirely in the
// clk_i domain from oversampled JTAG pins. 5-bit IR, BYPASS, optional IDCODE,
// and one user DR exposed as a capture/update port.
// Build option: define JTAG_TAP_IDCODE_EN to include the IDCODE register and
// make it the reset instruction; otherwise 5'h01 decodes as BYPASS and the
// IR resets to 5'h1F.
module jtag_tap_oversampled
   import jtag_tap_pkg::*;
#(
   parameter logic [31:0]         IDCODE      = 32'h1BEE_F001,
   parameter int unsigned         IR_WIDTH    = 5,
   parameter int unsigned         DR_WIDTH    = 32,
   parameter logic [IR_WIDTH-1:0] USER_IR     = 5'h10,
   parameter int unsigned         SYNC_STAGES = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                jtag_tck_i,
   input  logic                jtag_tms_i,
   input  logic                jtag_tdi_i,
   input  logic                jtag_trst_ni,
   output logic                jtag_tdo_o,
   output logic                jtag_tdo_oe_o,
   output logic                dr_capture_o,
   input  logic [DR_WIDTH-1:0] dr_capture_data_i,
   output logic                dr_update_o,
   output logic [DR_WIDTH-1:0] dr_update_data_o
);

   localparam int unsigned SHIFT_W    = (DR_WIDTH > 32) ? DR_WIDTH : 32;
   localparam int unsigned IDCODE_LEN = 32;

`ifdef JTAG_TAP_IDCODE_EN
   localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(IR_IDCODE);
`else
   localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(IR_BYPASS);
`endif

   logic tms_s, tdi_s, trst_s, tck_rise, tck_fall;

   jtag_tap_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .tck_i      (jtag_tck_i),
      .tms_i      (jtag_tms_i),
      .tdi_i      (jtag_tdi_i),
      .trst_ni    (jtag_trst_ni),
      .tms_o      (tms_s),
      .tdi_o      (tdi_s),
      .trst_no    (trst_s),
      .tck_rise_o (tck_rise),
      .tck_fall_o (tck_fall)
   );

   tap_state_e            state_q, state_d;
   logic [IR_WIDTH-1:0]   ir_q;
   logic [SHIFT_W-1:0]    shift_q, shift_d, capture_val;
   logic                  tdo_q, tdo_oe_q, dr_capture_q, dr_update_q;
   logic [DR_WIDTH-1:0]   dr_update_data_q;
   dr_sel_e               dr_sel;
   int unsigned           shift_len;

   assign state_d = tap_next_state(state_q, tms_s);

   // Instruction decode: anything not recognised selects BYPASS.
   always_comb begin
      dr_sel = DR_SEL_BYPASS;
      if (ir_q == USER_IR) begin
         dr_sel = DR_SEL_USER;
      end
`ifdef JTAG_TAP_IDCODE_EN
      else if (ir_q == IR_WIDTH'(IR_IDCODE)) begin
         dr_sel = DR_SEL_IDCODE;
      end
`endif
   end

   // Value parallel-loaded into the shared shift register in Capture-IR/DR.
   always_comb begin
      capture_val = '0;
      if (state_q == CAPTURE_IR) begin
         capture_val[IR_WIDTH-1:0] = IR_WIDTH'(IR_CAPTURE);
      end else begin
         case (dr_sel)
            DR_SEL_IDCODE: capture_val[IDCODE_LEN-1:0] = IDCODE;
            DR_SEL_USER:   capture_val[DR_WIDTH-1:0]   = dr_capture_data_i;
            default:       capture_val                 = '0;
         endcase
      end
   end

   // One shift step: TDI enters at the MSB of the currently selected
   // register length, so shorter registers reuse the low bits of one shifter.
   always_comb begin
      shift_len = 1;
      if (state_q == SHIFT_IR) begin
         shift_len = IR_WIDTH;
      end else if (dr_sel == DR_SEL_IDCODE) begin
         shift_len = IDCODE_LEN;
      end else if (dr_sel == DR_SEL_USER) begin
         shift_len = DR_WIDTH;
      end
      shift_d = shift_q >> 1;
      for (int unsigned i = 0; i < SHIFT_W; i++) begin
         if (i == shift_len - 1) begin
            shift_d[i] = tdi_s;
         end
      end
   end

   // TAP FSM with IR, shifter and all registered outputs; synced trst_n
   // overrides any TCK strobe arriving in the same cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q          <= TEST_LOGIC_RESET;
         ir_q             <= IR_RESET;
         shift_q          <= '0;
         tdo_q            <= 1'b0;
         tdo_oe_q         <= 1'b0;
         dr_capture_q     <= 1'b0;
         dr_update_q      <= 1'b0;
         dr_update_data_q <= '0;
      end else if (!trst_s) begin
         state_q      <= TEST_LOGIC_RESET;
         ir_q         <= IR_RESET;
         shift_q      <= '0;
         tdo_q        <= 1'b0;
         tdo_oe_q     <= 1'b0;
         dr_capture_q <= 1'b0;
         dr_update_q  <= 1'b0;
      end else begin
         dr_capture_q <= 1'b0;
         dr_update_q  <= 1'b0;
         if (tck_rise) begin
            state_q  <= state_d;
            tdo_oe_q <= (state_d == SHIFT_IR) || (state_d == SHIFT_DR);
            if (state_d == TEST_LOGIC_RESET) begin
               ir_q <= IR_RESET;
            end
            if ((state_d == CAPTURE_DR) && (dr_sel == DR_SEL_USER)) begin
               dr_capture_q <= 1'b1;
            end
            if ((state_q == CAPTURE_IR) || (state_q == CAPTURE_DR)) begin
               shift_q <= capture_val;
            end else if ((state_q == SHIFT_IR) || (state_q == SHIFT_DR)) begin
               shift_q <= shift_d;
            end
         end
         if (tck_fall) begin
            case (state_q)
               SHIFT_IR, SHIFT_DR: tdo_q <= shift_q[0];
               UPDATE_IR:          ir_q  <= shift_q[IR_WIDTH-1:0];
               UPDATE_DR: begin
                  if (dr_sel == DR_SEL_USER) begin
                     dr_update_data_q <= shift_q[DR_WIDTH-1:0];
                     dr_update_q      <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign jtag_tdo_o       = tdo_q;
   assign jtag_tdo_oe_o    = tdo_oe_q;
   assign dr_capture_o     = dr_capture_q;
   assign dr_update_o      = dr_update_q;
   assign dr_update_data_o = dr_update_data_q;

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// tb_jtag_tap_oversampled: JTAG master driving the oversampled TAP, with a
// queue-based model of each scan (register contents LSB first, capture value
// streamed out ahead of the TDI bits) plus literal expectations.
module tb_jtag_tap_oversampled;

   localparam logic [31:0] IDC   = 32'h1BEE_F001;
   localparam logic [4:0]  USER  = 5'h10;
   localparam int unsigned HALF  = 6;
`ifdef JTAG_TAP_IDCODE_EN
   localparam logic [4:0]  IR_RST = 5'h01;
`else
   localparam logic [4:0]  IR_RST = 5'h1F;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tck = 1'b0, tms = 1'b1, tdi = 1'b0, trst_n = 1'b1;
   logic        jtag_tdo, jtag_tdo_oe, dr_capture, dr_update;
   logic [31:0] cap_data = '0;
   logic [31:0] dr_update_data;

   int checks = 0, errors = 0;
   int cap_cnt = 0, upd_cnt = 0, cap_exp = 0, upd_exp = 0;
   logic [4:0]  ir_m;
   logic [31:0] upd_m = '0;

   always #5 clk = ~clk;

   jtag_tap_oversampled #(
      .IDCODE      (IDC),
      .IR_WIDTH    (5),
      .DR_WIDTH    (32),
      .USER_IR     (USER),
      .SYNC_STAGES (2)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .jtag_tck_i        (tck),
      .jtag_tms_i        (tms),
      .jtag_tdi_i        (tdi),
      .jtag_trst_ni      (trst_n),
      .jtag_tdo_o        (jtag_tdo),
      .jtag_tdo_oe_o     (jtag_tdo_oe),
      .dr_capture_o      (dr_capture),
      .dr_capture_data_i (cap_data),
      .dr_update_o       (dr_update),
      .dr_update_data_o  (dr_update_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (dr_capture === 1'b1) cap_cnt++;
      if (dr_update === 1'b1) upd_cnt++;
   end

   // Per-cycle: any change of the update value outside reset is a pulse
   // cycle and must carry the value the model predicts.
   initial begin : cmp
      logic [31:0] prev;
      logic        r;
      prev = '0;
      forever begin
         @(posedge clk);
         r = rst_n;
         #1;
         if (r === 1'b1 && dr_update_data !== prev) begin
            check("update_pulse_with_change", {31'b0, dr_update}, 32'd1);
            check("update_value", dr_update_data, upd_m);
         end
         prev = dr_update_data;
      end
   end

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // One TCK period: TMS/TDI set in the low phase, TDO/OE sampled just before
   // the rising edge (well after the previous falling edge has propagated).
   task automatic tck_io(input logic tms_v, input logic tdi_v, output logic tdo_v, output logic oe_v);
      @(negedge clk);
      tms = tms_v;
      tdi = tdi_v;
      repeat (HALF - 1) @(negedge clk);
      tdo_v = jtag_tdo;
      oe_v  = jtag_tdo_oe;
      tck   = 1'b1;
      repeat (HALF) @(negedge clk);
      tck   = 1'b0;
   endtask

   task automatic tck_chk(input logic tms_v);
      logic t, o;
      tck_io(tms_v, 1'b0, t, o);
      check("oe_outside_shift", {31'b0, o}, 32'd0);
   endtask

   function automatic int unsigned m_len(input logic [4:0] ir);
      if (ir == USER) return 32;
`ifdef JTAG_TAP_IDCODE_EN
      if (ir == 5'h01) return 32;
`endif
      return 1;
   endfunction

   function automatic logic [31:0] m_cap(input logic [4:0] ir, input logic [31:0] ud);
      if (ir == USER) return ud;
`ifdef JTAG_TAP_IDCODE_EN
      if (ir == 5'h01) return IDC;
`endif
      return 32'd0;
   endfunction

   task automatic reset_tap();
      repeat (5) tck_chk(1'b1);
      ir_m = IR_RST;
      tck_chk(1'b0);
   endtask

   // From Run-Test/Idle: full IR scan back to Run-Test/Idle.
   task automatic scan_ir(input logic [4:0] v, output logic [4:0] dout);
      logic q[$];
      logic [4:0] cap;
      logic t, o, e;
      cap = 5'b00001;
      for (int unsigned j = 0; j < 5; j++) q.push_back(cap[j]);
      tck_chk(1'b1); tck_chk(1'b1); tck_chk(1'b0); tck_chk(1'b0);
      for (int unsigned i = 0; i < 5; i++) begin
         e = q.pop_front();
         q.push_back(v[i]);
         tck_io(i == 4, v[i], t, o);
         check("ir_tdo", {31'b0, t}, {31'b0, e});
         check("ir_oe", {31'b0, o}, 32'd1);
         dout[i] = t;
      end
      for (int unsigned j = 0; j < 5; j++) ir_m[j] = q[j];
      tck_chk(1'b1); tck_chk(1'b0);
   endtask

   // From Run-Test/Idle: DR scan of n bits with the model predicting TDO.
   task automatic scan_dr(input int unsigned n, input logic [31:0] din, output logic [31:0] dout);
      logic q[$];
      logic [31:0] cap, r;
      int unsigned len;
      logic t, o, e;
      len = m_len(ir_m);
      cap = m_cap(ir_m, cap_data);
      for (int unsigned j = 0; j < len; j++) q.push_back(cap[j]);
      if (ir_m == USER) cap_exp++;
      tck_chk(1'b1); tck_chk(1'b0); tck_chk(1'b0);
      dout = '0;
      for (int unsigned i = 0; i < n; i++) begin
         e = q.pop_front();
         q.push_back(din[i]);
         tck_io(i == n - 1, din[i], t, o);
         if (i == 0) cap_data = $urandom;
         check("dr_tdo", {31'b0, t}, {31'b0, e});
         check("dr_oe", {31'b0, o}, 32'd1);
         dout[i] = t;
      end
      r = '0;
      for (int unsigned j = 0; j < len; j++) r[j] = q[j];
      if (ir_m == USER) begin
         upd_m = r;
         upd_exp++;
      end
      tck_chk(1'b1); tck_chk(1'b0);
      check("capture_pulses", cap_cnt, cap_exp);
      check("update_pulses", upd_cnt, upd_exp);
      check("update_data", dr_update_data, upd_m);
   endtask

   initial begin : main
      logic [31:0] d;
      logic [4:0]  ir_out, irv;
      logic        t, o;
      int unsigned n;

      repeat (4) @(negedge clk);
      check("rst_tdo", {31'b0, jtag_tdo}, 32'd0);
      check("rst_oe", {31'b0, jtag_tdo_oe}, 32'd0);
      check("rst_capture", {31'b0, dr_capture}, 32'd0);
      check("rst_update", {31'b0, dr_update}, 32'd0);
      check("rst_update_data", dr_update_data, 32'd0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      reset_tap();
`ifdef JTAG_TAP_IDCODE_EN
      scan_dr(32, 32'h0, d);
      check("idcode_after_tlr", d, IDC);
`else
      scan_dr(8, 32'hFF, d);
      check("bypass_after_tlr", d & 32'hFF, 32'hFE);
`endif

      scan_ir(5'h01, ir_out);
      check("ir_capture_pattern", {27'b0, ir_out}, 32'd1);
`ifdef JTAG_TAP_IDCODE_EN
      scan_dr(32, 32'hFFFF_FFFF, d);
      check("idcode_after_ir01", d, IDC);
`else
      scan_dr(4, 32'hF, d);
      check("ir01_is_bypass", d & 32'hF, 32'hE);
`endif

      scan_ir(USER, ir_out);
      cap_data = 32'h0000_5071;
      scan_dr(32, 32'hA5A5_0F0F, d);
      check("user_capture_out", d, 32'h0000_5071);
      check("user_update_literal", dr_update_data, 32'hA5A5_0F0F);
      check("user_pulse_counts", cap_cnt + upd_cnt, 32'd2);

      scan_ir(5'h1F, ir_out);
      scan_dr(8, 32'hC3, d);
      check("bypass_c3", d & 32'hFF, 32'h86);
      check("bypass_no_update", dr_update_data, 32'hA5A5_0F0F);

      // trst_n mid Shift-DR, with a TCK edge arriving while it is held low.
      scan_ir(USER, ir_out);
      cap_data = 32'h1234_5678;
      tck_chk(1'b1); tck_chk(1'b0); cap_exp++; tck_chk(1'b0);
      for (int unsigned i = 0; i < 10; i++) begin
         tck_io(1'b0, i[0], t, o);
         check("oe_before_trst", {31'b0, o}, 32'd1);
      end
      @(negedge clk); trst_n = 1'b0;
      repeat (3) @(negedge clk); tck = 1'b1;
      repeat (6) @(negedge clk); tck = 1'b0;
      repeat (6) @(negedge clk);
      check("trst_oe", {31'b0, jtag_tdo_oe}, 32'd0);
      check("trst_update_data_kept", dr_update_data, 32'hA5A5_0F0F);
      trst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("trst_no_update", upd_cnt, upd_exp);
      check("trst_capture_count", cap_cnt, cap_exp);
      ir_m = IR_RST;
      tck_chk(1'b0);
`ifdef JTAG_TAP_IDCODE_EN
      scan_dr(32, 32'h0, d);
      check("trst_ir_idcode", d, IDC);
`else
      scan_dr(3, 32'h7, d);
      check("trst_ir_bypass", d & 32'h7, 32'h6);
`endif

      // rst_ni mid Shift-DR.
      scan_ir(USER, ir_out);
      cap_data = 32'hFFFF_FFFF;
      tck_chk(1'b1); tck_chk(1'b0); cap_exp++; tck_chk(1'b0);
      for (int unsigned i = 0; i < 5; i++) tck_io(1'b0, 1'b1, t, o);
      @(negedge clk); rst_n = 1'b0;
      upd_m = '0;
      @(negedge clk);
      check("rst_mid_tdo", {31'b0, jtag_tdo}, 32'd0);
      check("rst_mid_oe", {31'b0, jtag_tdo_oe}, 32'd0);
      check("rst_mid_update_data", dr_update_data, 32'd0);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("rst_mid_no_update", upd_cnt, upd_exp);
      ir_m = IR_RST;
      tck_chk(1'b0);

      // Randomized scans against the model.
      for (int unsigned it = 0; it < 25; it++) begin
         if ($urandom_range(0, 5) == 0) reset_tap();
         repeat ($urandom_range(0, 2)) tck_chk(1'b0);
         case ($urandom_range(0, 3))
            0:       irv = 5'h01;
            1:       irv = USER;
            2:       irv = 5'h1F;
            default: irv = 5'($urandom);
         endcase
         scan_ir(irv, ir_out);
         cap_data = $urandom;
         if (m_len(ir_m) == 32)
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31) : 32;
         else
            n = $urandom_range(1, 20);
         scan_dr(n, $urandom, d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/jtag_tap_oversampled.md
# jtag_tap_oversampled

Device-side JTAG TAP controller: the responder to the bench's JTAG master driving the board's jtag_tck/tms/tdi/trst_n pins. It oversamples all JTAG pins in the system clock domain rather than clocking logic on TCK. It implements the IEEE 1149.1 16-state TAP FSM, a 5-bit IR, and IDCODE, BYPASS and one user DR. The user DR is exposed as a capture/update port to the debug-module interface (DTMCS-style register).

## Interface
- IDCODE, 32'h1BEE_F001, value shifted out for IDCODE instruction (bit 0 must be 1)
- IR_WIDTH, 5, instruction register width
- DR_WIDTH, 32, user data register width
- USER_IR, 5'h10, instruction selecting the user DR
- SYNC_STAGES, 2, synchronizer flops per JTAG input (≥2)
- Clocking: one clock; reset is synchronous and active-low.
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous active-low reset
- jtag_tck_i  in  1  asynchronous TCK
- jtag_tms_i  in  1  TMS
- jtag_tdi_i  in  1  TDI
- jtag_trst_ni  in  1  asynchronous active-low test reset
- jtag_tdo_o  out  1  TDO
- jtag_tdo_oe_o  out  1  TDO driver enable
- dr_capture_o  out  1  one-cycle pulse: user DR about to capture
- dr_capture_data_i  in  DR_WIDTH  value loaded at Capture-DR
- dr_update_o  out  1  one-cycle pulse: user DR updated
- dr_update_data_o  out  DR_WIDTH  last updated user DR value

## Operation
- tck/tms/tdi/trst_n each pass through SYNC_STAGES flops; a registered copy of synced TCK gives tck_rise / tck_fall one-cycle strobes.
- tck_rise: advance FSM on synced TMS; in Capture-* load shift register; in Shift-* shift synced TDI into MSB, shift right.
- tck_fall: jtag_tdo_o <= shift register bit 0 when in Shift-IR/Shift-DR; Update-IR latches IR; Update-DR (user DR) latches dr_update_data_o.
- FSM: the 16 standard states. Test-Logic-Reset entered on reset, synced trst_n low (overrides everything), or five consecutive TMS=1 rises.
- IR capture value 5'b00001. IR reset value IDCODE (5'h01). Decode: 5'h01 IDCODE (32-bit, captures IDCODE), USER_IR user DR (captures dr_capture_data_i), 5'h1F and all others BYPASS (1 bit, captures 0).
- dr_capture_o: pulses in the cycle of the tck_rise entering Capture-DR with user DR selected. dr_capture_data_i is sampled at the following tck_rise and must be stable from pulse+1 onward.
- dr_update_o: pulses in the cycle dr_update_data_o changes (tck_fall in Update-DR, user DR selected). No pulse for IDCODE/BYPASS.
- jtag_tdo_oe_o = 1 only while the FSM is in Shift-IR or Shift-DR.
- Simultaneous tck edge and trst_n low: reset wins, edge discarded.

## Timing
- Reset values: jtag_tdo_o 0, jtag_tdo_oe_o 0, dr_capture_o 0, dr_update_o 0, dr_update_data_o 0, FSM Test-Logic-Reset, IR 5'h01, sync flops 0 (TCK low, trst_n treated as asserted until synced).
- TCK high and low phases must each be ≥ SYNC_STAGES+2 clk_i cycles; at default, TCK ≤ clk_i/8. Faster TCK is out of spec; behaviour is undefined but must not lock up after trst_n.
- Pin TCK edge to strobe: SYNC_STAGES+1 cycles. Falling TCK pin to TDO pin: SYNC_STAGES+2 cycles.
- rst_ni low mid-shift: all state to reset values next cycle, no update pulse.

## Configuration
- JTAG_TAP_IDCODE_EN defined: IDCODE register and instruction present, IR reset value 5'h01.
- Undefined: no IDCODE register; 5'h01 decodes as BYPASS; IR reset value 5'h1F; Shift-DR after TLR yields a single 0 bit per BYPASS.

## Structure
- jtag_tap_pkg: tap_state_e (16 states), IR constants (IR_IDCODE, IR_BYPASS, IR_CAPTURE = 5'b00001), next-state function.
- Sub-module jtag_tap_sync: synchronizer chain plus tck_rise/tck_fall edge strobes, parameterized by SYNC_STAGES.
- Top: FSM, IR, shared shift register (max of DR_WIDTH, 32), TDO register, user-DR port.

## Test plan
- Reset, 5×TMS=1, go to Shift-DR, shift 32 bits -> TDO yields 32'h1BEE_F001 LSB first; oe high only during shift.
- Shift-IR 5 bits with TDI=0 -> TDO yields 1,0,0,0,0; IR remains IDCODE after Update-IR with 5'h01.
- Load IR 5'h10, dr_capture_data_i=32'h0000_5071, shift in 32'hA5A5_0F0F -> TDO yields 32'h0000_5071; one dr_capture_o and one dr_update_o; dr_update_data_o = 32'hA5A5_0F0F.
- Load IR 5'h1F, shift 8 bits 8'hC3 -> TDO is 0 then 8'hC3 delayed one TCK; no dr_update_o.
- Mid Shift-DR (user DR) pull jtag_trst_ni low -> FSM TLR, IR 5'h01, oe 0, no dr_update_o, dr_update_data_o unchanged.
- Build without JTAG_TAP_IDCODE_EN, reset, Shift-DR 8 bits 8'hFF -> TDO 0 then 1s (BYPASS).
